binary_search_arbiter: RTL and testbench

- Shares one binary_searcher instance (controller, datapath and its 32x8 RAM) among N_REQ independent requesters.
- Grants the searcher round-robin and latches the winner's target.
- Drives the searcher's start/done handshake to completion, then returns found/index to the winner as a one-cycle response.
- Sits between client logic (e.g. switch/key front-ends) and the searcher.

---
 rtl/binary_search_arbiter.sv | 161 ++++++++++++++++
 tb/tb_binary_search_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_search_arbiter.sv
// Round-robin arbiter that shares one binary_searcher among N_REQ requesters.
// Optional launch watchdog with a timeout output: define BSA_TIMEOUT_EN.
module binary_search_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_target,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        resp_valid,
    output logic                    resp_found,
    output logic [ADDR_W-1:0]       resp_index,
    output logic                    srch_start,
    output logic [DATA_W-1:0]       srch_target,
    input  logic                    srch_ready,
    input  logic                    srch_done,
    input  logic                    srch_found,
    input  logic [ADDR_W-1:0]       srch_index,
    output logic                    busy
`ifdef BSA_TIMEOUT_EN
    ,
    output logic                    timeout
`endif
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RELEASE, S_DRAIN} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     r_ptr;
    logic [N_REQ-1:0]    r_grant;
    logic                r_found;
    logic [ADDR_W-1:0]   r_index;
    logic [DATA_W-1:0]   r_target;

    logic [N_REQ-1:0]    w_rot;
    logic [ID_W:0]       w_off;
    logic [ID_W:0]       w_sum;
    logic [ID_W-1:0]     w_sel_id;
    logic [DATA_W-1:0]   w_sel_target;
    logic [ID_W-1:0]     w_next_ptr;
    logic                w_launch;
    logic                w_expire;

    // Rotate req so bit 0 is the requester at the rr pointer; lowest set bit wins.
    assign w_rot    = N_REQ'({req, req} >> r_ptr);
    assign w_launch = (|req) && srch_ready;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = (ID_W+1)'(k);
        end
        w_sum = {1'b0, r_ptr} + w_off;
        if (w_sum >= (ID_W+1)'(N_REQ)) w_sel_id = ID_W'(w_sum - (ID_W+1)'(N_REQ));
        else                           w_sel_id = w_sum[ID_W-1:0];
    end

    always_comb begin
        w_sel_target = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_sel_id == ID_W'(k)) w_sel_target = req_target[k*DATA_W +: DATA_W];
        end
    end

    assign w_next_ptr = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;

`ifdef BSA_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign timeout  = (r_state == S_RELEASE) && r_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_cnt     <= r_cnt + 1'b1;
            r_timeout <= !srch_done && w_expire;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_launch)               w_next_state = S_LAUNCH;
            S_LAUNCH:  if (srch_done || w_expire)  w_next_state = S_RELEASE;
            S_RELEASE:                             w_next_state = S_DRAIN;
            S_DRAIN:   if (srch_ready)             w_next_state = S_IDLE;
            default:                               w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_id     <= '0;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_found  <= 1'b0;
            r_index  <= '0;
            r_target <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_id     <= w_sel_id;
                        r_target <= w_sel_target;
                        r_grant  <= N_REQ'(1) << w_sel_id;
                    end
                end
                S_LAUNCH: begin
                    // Index is zeroed on a miss or timeout rather than passed through.
                    if (srch_done) begin
                        r_found <= srch_found;
                        r_index <= srch_found ? srch_index : '0;
                    end else if (w_expire) begin
                        r_found <= 1'b0;
                        r_index <= '0;
                    end
                end
                S_RELEASE: begin
                    r_grant <= '0;
                    r_ptr   <= w_next_ptr;
                end
                default: ;
            endcase
        end
    end

    assign grant       = r_grant;
    assign resp_valid  = (r_state == S_RELEASE) ? r_grant : '0;
    assign resp_found  = r_found;
    assign resp_index  = r_index;
    assign srch_start  = (r_state == S_LAUNCH);
    assign srch_target = r_target;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_binary_search_arbiter.sv
// Directed bench for binary_search_arbiter with a behavioural searcher model
// (32-entry table, fixed search latency, FINISHING cycle before ready returns).
module tb_binary_search_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_target;
    logic [3:0]  grant;
    logic [3:0]  resp_valid;
    logic        resp_found;
    logic [4:0]  resp_index;
    logic        srch_start;
    logic [7:0]  srch_target;
    logic        srch_busy;
    logic        m_ready;
    logic        m_done;
    logic        m_found;
    logic [4:0]  m_index;
`ifdef BSA_TIMEOUT_EN
    logic        timeout;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [32];
    int         m_st;
    int         m_cnt;
    bit         m_hang;

    binary_search_arbiter #(
        .N_REQ(4), .DATA_W(8), .ADDR_W(5), .TIMEOUT_CYC(10)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_target(req_target),
        .grant(grant), .resp_valid(resp_valid), .resp_found(resp_found),
        .resp_index(resp_index), .srch_start(srch_start), .srch_target(srch_target),
        .srch_ready(m_ready), .srch_done(m_done), .srch_found(m_found),
        .srch_index(m_index), .busy(srch_busy)
`ifdef BSA_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic look_found(input logic [7:0] t);
        for (int i = 0; i < 32; i++) if (mem[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    // A miss returns a junk index so the arbiter's zeroing is observable.
    function automatic logic [4:0] look_index(input logic [7:0] t);
        for (int i = 0; i < 32; i++) if (mem[i] == t) return 5'(i);
        return 5'd17;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_st <= 0; m_cnt <= 0; m_ready <= 1'b1; m_done <= 1'b0;
            m_found <= 1'b0; m_index <= '0;
        end else begin
            case (m_st)
                0: if (srch_start) begin m_st <= 1; m_ready <= 1'b0; m_cnt <= 0; end
                1: if (!m_hang) begin
                       if (m_cnt == 1) begin
                           m_st <= 2; m_done <= 1'b1;
                           m_found <= look_found(srch_target);
                           m_index <= look_index(srch_target);
                       end else m_cnt <= m_cnt + 1;
                   end
                2: if (!srch_start) begin m_done <= 1'b0; m_st <= 3; end
                default: begin m_ready <= 1'b1; m_st <= 0; end
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; req = '0;
        tick; tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic wait_resp(output bit to, output bit multi, output bit start_drop,
                             output bit done_prev, output int cyc);
        bit prev;
        to = 1'b1; multi = 1'b0; start_drop = 1'b0; done_prev = 1'b0; cyc = 0;
        prev = m_done;
        for (int i = 0; i < 200; i++) begin
            tick;
            cyc = i + 1;
            if (!$onehot0(grant)) multi = 1'b1;
            if (|resp_valid) begin to = 1'b0; done_prev = prev; break; end
            if (grant != '0 && !srch_start) start_drop = 1'b1;
            prev = m_done;
        end
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (!srch_busy) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (grant !== 4'b0 || resp_valid !== 4'b0) begin failures++; $display("FAIL rst_grant_valid got grant=%b valid=%b exp 0000/0000", grant, resp_valid); end
        checks++; if (srch_start !== 1'b0 || srch_busy !== 1'b0) begin failures++; $display("FAIL rst_start_busy got start=%b busy=%b exp 0/0", srch_start, srch_busy); end
        checks++; if (resp_found !== 1'b0 || resp_index !== 5'd0 || srch_target !== 8'd0) begin failures++; $display("FAIL rst_data got found=%b idx=%0d tgt=%0d exp 0/0/0", resp_found, resp_index, srch_target); end
    endtask

    task automatic test_single;
        bit to, multi, sd, dp; int cyc;
        req = 4'b0001; req_target = {8'd0, 8'd0, 8'd0, 8'd100};
        tick;
        checks++; if (grant !== 4'b0001 || srch_start !== 1'b1 || srch_busy !== 1'b1) begin failures++; $display("FAIL single_grant got grant=%b start=%b busy=%b exp 0001/1/1", grant, srch_start, srch_busy); end
        checks++; if (srch_target !== 8'd100) begin failures++; $display("FAIL single_target got %0d exp 100", srch_target); end
        wait_resp(to, multi, sd, dp, cyc);
        checks++; if (to) begin failures++; $display("FAIL single_timeout got no resp_valid exp a response"); end
        checks++; if (resp_valid !== 4'b0001 || resp_found !== 1'b1 || resp_index !== 5'd6) begin failures++; $display("FAIL single_resp got valid=%b found=%b idx=%0d exp 0001/1/6", resp_valid, resp_found, resp_index); end
        checks++; if (sd || !dp || srch_start !== 1'b0) begin failures++; $display("FAIL single_handshake got start_drop=%b done_prev=%b start=%b exp 0/1/0", sd, dp, srch_start); end
        req = '0;
        tick;
        checks++; if (resp_valid !== 4'b0 || grant !== 4'b0 || resp_found !== 1'b1 || resp_index !== 5'd6) begin failures++; $display("FAIL single_after got valid=%b grant=%b found=%b idx=%0d exp 0000/0000/1/6", resp_valid, grant, resp_found, resp_index); end
        wait_idle(to);
        checks++; if (to || m_ready !== 1'b1) begin failures++; $display("FAIL single_idle got stuck=%b ready=%b exp 0/1", to, m_ready); end
    endtask

    task automatic test_not_found;
        bit to, multi, sd, dp; int cyc;
        mem[6] = 8'd99;
        req = 4'b0010; req_target = {8'd0, 8'd0, 8'd100, 8'd0};
        tick;
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL nf_grant got %b exp 0010", grant); end
        req_target = {8'd0, 8'd0, 8'd10, 8'd0};
        wait_resp(to, multi, sd, dp, cyc);
        checks++; if (to || resp_valid !== 4'b0010 || resp_found !== 1'b0 || resp_index !== 5'd0) begin failures++; $display("FAIL nf_resp got to=%b valid=%b found=%b idx=%0d exp 0/0010/0/0", to, resp_valid, resp_found, resp_index); end
        checks++; if (srch_target !== 8'd100) begin failures++; $display("FAIL nf_latched_target got %0d exp 100", srch_target); end
        req = '0;
        wait_idle(to);
        mem[6] = 8'd100;
    endtask

    task automatic test_round_robin;
        bit to, multi, sd, dp; int cyc;
        logic [3:0] exp_v [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic       exp_f [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0] exp_i [5] = '{5'd1, 5'd0, 5'd3, 5'd31, 5'd1};
        do_reset;
        req = 4'b1111; req_target = {8'd40, 8'd30, 8'd20, 8'd10};
        for (int n = 0; n < 5; n++) begin
            wait_resp(to, multi, sd, dp, cyc);
            if (n == 4) req = '0;
            checks++; if (to || resp_valid !== exp_v[n] || grant !== exp_v[n]) begin failures++; $display("FAIL rr_order[%0d] got to=%b valid=%b grant=%b exp %b", n, to, resp_valid, grant, exp_v[n]); end
            checks++; if (resp_found !== exp_f[n] || resp_index !== exp_i[n]) begin failures++; $display("FAIL rr_result[%0d] got found=%b idx=%0d exp %b/%0d", n, resp_found, resp_index, exp_f[n], exp_i[n]); end
            checks++; if (multi) begin failures++; $display("FAIL rr_onehot[%0d] got multiple grant bits exp at most one", n); end
        end
        wait_idle(to);
    endtask

    task automatic test_back_to_back;
        bit to, multi, sd, dp; int cyc;
        logic [3:0] exp_v [3] = '{4'b0100, 4'b0001, 4'b0100};
        logic [4:0] exp_i [3] = '{5'd3, 5'd6, 5'd3};
        req = 4'b0010; req_target = {8'd0, 8'd0, 8'd20, 8'd0};
        wait_resp(to, multi, sd, dp, cyc);
        req = '0;
        checks++; if (to || resp_valid !== 4'b0010) begin failures++; $display("FAIL b2b_setup got to=%b valid=%b exp 0/0010", to, resp_valid); end
        wait_idle(to);
        req = 4'b0101; req_target = {8'd0, 8'd30, 8'd0, 8'd100};
        for (int n = 0; n < 3; n++) begin
            wait_resp(to, multi, sd, dp, cyc);
            if (n == 2) req = '0;
            checks++; if (to || resp_valid !== exp_v[n] || resp_found !== 1'b1 || resp_index !== exp_i[n]) begin failures++; $display("FAIL b2b_order[%0d] got to=%b valid=%b found=%b idx=%0d exp %b/1/%0d", n, to, resp_valid, resp_found, resp_index, exp_v[n], exp_i[n]); end
        end
        wait_idle(to);
    endtask

    task automatic test_reset_mid;
        bit to, multi, sd, dp; int cyc;
        req = 4'b1000; req_target = {8'd40, 8'd0, 8'd0, 8'd10};
        tick;
        checks++; if (grant !== 4'b1000 || srch_start !== 1'b1) begin failures++; $display("FAIL rmid_launch got grant=%b start=%b exp 1000/1", grant, srch_start); end
        tick;
        reset = 1'b1; req = 4'b1001;
        tick;
        checks++; if (grant !== 4'b0 || resp_valid !== 4'b0 || srch_start !== 1'b0 || srch_busy !== 1'b0) begin failures++; $display("FAIL rmid_ctrl got grant=%b valid=%b start=%b busy=%b exp 0000/0000/0/0", grant, resp_valid, srch_start, srch_busy); end
        checks++; if (resp_found !== 1'b0 || resp_index !== 5'd0 || srch_target !== 8'd0) begin failures++; $display("FAIL rmid_data got found=%b idx=%0d tgt=%0d exp 0/0/0", resp_found, resp_index, srch_target); end
        reset = 1'b0;
        tick;
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rmid_ptr got grant=%b exp 0001", grant); end
        wait_resp(to, multi, sd, dp, cyc);
        req = 4'b1000;
        checks++; if (to || resp_valid !== 4'b0001 || resp_found !== 1'b1 || resp_index !== 5'd1) begin failures++; $display("FAIL rmid_first got to=%b valid=%b found=%b idx=%0d exp 0/0001/1/1", to, resp_valid, resp_found, resp_index); end
        wait_resp(to, multi, sd, dp, cyc);
        req = '0;
        checks++; if (to || resp_valid !== 4'b1000 || resp_found !== 1'b1 || resp_index !== 5'd31) begin failures++; $display("FAIL rmid_reserve got to=%b valid=%b found=%b idx=%0d exp 0/1000/1/31", to, resp_valid, resp_found, resp_index); end
        wait_idle(to);
    endtask

`ifdef BSA_TIMEOUT_EN
    task automatic test_timeout;
        bit to, multi, sd, dp; int cyc;
        do_reset;
        m_hang = 1'b1;
        req = 4'b0001; req_target = {8'd0, 8'd0, 8'd20, 8'd10};
        tick;
        wait_resp(to, multi, sd, dp, cyc);
        req = 4'b0010;
        checks++; if (to || cyc != 10 || resp_valid !== 4'b0001) begin failures++; $display("FAIL to_latency got to=%b cyc=%0d valid=%b exp 0/10/0001", to, cyc, resp_valid); end
        checks++; if (timeout !== 1'b1 || resp_found !== 1'b0 || resp_index !== 5'd0) begin failures++; $display("FAIL to_flags got timeout=%b found=%b idx=%0d exp 1/0/0", timeout, resp_found, resp_index); end
        repeat (5) tick;
        checks++; if (grant !== 4'b0 || srch_busy !== 1'b1) begin failures++; $display("FAIL to_drain got grant=%b busy=%b exp 0000/1", grant, srch_busy); end
        m_hang = 1'b0;
        wait_resp(to, multi, sd, dp, cyc);
        req = '0;
        checks++; if (to || resp_valid !== 4'b0010 || timeout !== 1'b0) begin failures++; $display("FAIL to_next got to=%b valid=%b timeout=%b exp 0/0010/0", to, resp_valid, timeout); end
        wait_idle(to);
    endtask
`endif

    initial begin
        reset = 1'b1; req = '0; req_target = '0; m_hang = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'(200 + i);
        mem[1] = 8'd10; mem[3] = 8'd30; mem[6] = 8'd100; mem[31] = 8'd40;
        test_reset;
        test_single;
        test_not_found;
        test_round_robin;
        test_back_to_back;
        test_reset_mid;
`ifdef BSA_TIMEOUT_EN
        test_timeout;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
